// File: rtl/hazard_unit_mc.sv
// MIPS 5-stage hazard controller: load-use stall FSM, MDU busy tracking, IF/ID flush, EX forwarding.
// Stall/flush/forward outputs are combinational from current ID/EX/MEM/WB state; all forced low during rst.
module hazard_unit_mc #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MDU_LATENCY       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Branch,
  input  logic                  Jump,
  input  logic [REG_ADDR_W-1:0] rsAddr_id,
  input  logic [REG_ADDR_W-1:0] rtAddr_id,
  input  logic [REG_ADDR_W-1:0] rsAddr_ex,
  input  logic [REG_ADDR_W-1:0] rtAddr_ex,
  input  logic                  MEM_MemRead_ex,
  input  logic [REG_ADDR_W-1:0] RegWriteAddr_ex,
  input  logic                  RegWrite_mem,
  input  logic [REG_ADDR_W-1:0] RegWriteAddr_mem,
  input  logic                  RegWrite_wb,
  input  logic [REG_ADDR_W-1:0] RegWriteAddr_wb,
  input  logic                  mdu_start_ex,
  input  logic                  mdu_use_id,
  output logic                  stall,
  output logic                  flush,
  output logic                  bubble_ex,
  output logic [1:0]            fwdA_sel,
  output logic [1:0]            fwdB_sel,
  output logic                  mdu_busy
);

  typedef enum logic {IDLE, LSTALL} state_t;

  localparam logic [2:0] LSC_M1  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [5:0] MDU_LAT = 6'(MDU_LATENCY);

  state_t     state_q, state_d;
  logic [2:0] lcnt_q, lcnt_d;
  logic [5:0] mcnt_q, mcnt_d;
  logic       lu_hit;
  logic       load_stall;

  assign lu_hit = MEM_MemRead_ex && (RegWriteAddr_ex != '0) &&
                  ((RegWriteAddr_ex == rsAddr_id) || (RegWriteAddr_ex == rtAddr_id));

  // In LSTALL the first stall cycle has already been spent in IDLE.
  assign load_stall = (state_q == LSTALL) || ((state_q == IDLE) && lu_hit);

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src);
    if (RegWrite_mem && (RegWriteAddr_mem != '0) && (RegWriteAddr_mem == src))
      return 2'b10;
    else if (RegWrite_wb && (RegWriteAddr_wb != '0) && (RegWriteAddr_wb == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    case (state_q)
      IDLE: begin
        if (lu_hit && (LOAD_STALL_CYCLES > 1)) begin
          state_d = LSTALL;
          lcnt_d  = LSC_M1;
        end
      end
      LSTALL: begin
        lcnt_d = lcnt_q - 3'd1;
        if (lcnt_q == 3'd1) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        lcnt_d  = '0;
      end
    endcase

    // A start always reloads, including a restart while still busy.
    if (mdu_start_ex)
      mcnt_d = MDU_LAT;
    else if (mcnt_q != '0)
      mcnt_d = mcnt_q - 6'd1;
    else
      mcnt_d = mcnt_q;
  end

  always_comb begin
    stall     = 1'b0;
    flush     = 1'b0;
    bubble_ex = 1'b0;
    fwdA_sel  = 2'b00;
    fwdB_sel  = 2'b00;
    mdu_busy  = 1'b0;
    if (!rst) begin
      mdu_busy  = (mcnt_q != '0);
      stall     = load_stall || (mdu_use_id && mdu_busy);
      bubble_ex = stall;
      flush     = (Branch || Jump) && !stall;
      fwdA_sel  = fwd_sel(rsAddr_ex);
      fwdB_sel  = fwd_sel(rtAddr_ex);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: two instances (3-cycle and 1-cycle load stall, MDU latency 4)
// share stimulus; expected outputs are queued per cycle and checked by a negedge monitor.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       Branch, Jump;
  logic [4:0] rsAddr_id, rtAddr_id, rsAddr_ex, rtAddr_ex;
  logic       MEM_MemRead_ex;
  logic [4:0] RegWriteAddr_ex;
  logic       RegWrite_mem, RegWrite_wb;
  logic [4:0] RegWriteAddr_mem, RegWriteAddr_wb;
  logic       mdu_start_ex, mdu_use_id;

  logic       stall3, flush3, bubble3, busy3;
  logic [1:0] fA3, fB3;
  logic       stall1, flush1, bubble1, busy1;
  logic [1:0] fA1, fB1;

  int checks   = 0;
  int failures = 0;

  string      q_nm[$];
  logic [7:0] q_e3[$];
  logic [7:0] q_e1[$];

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .MDU_LATENCY(4)) dut3 (
    .clk(clk), .rst(rst), .Branch(Branch), .Jump(Jump),
    .rsAddr_id(rsAddr_id), .rtAddr_id(rtAddr_id), .rsAddr_ex(rsAddr_ex), .rtAddr_ex(rtAddr_ex),
    .MEM_MemRead_ex(MEM_MemRead_ex), .RegWriteAddr_ex(RegWriteAddr_ex),
    .RegWrite_mem(RegWrite_mem), .RegWriteAddr_mem(RegWriteAddr_mem),
    .RegWrite_wb(RegWrite_wb), .RegWriteAddr_wb(RegWriteAddr_wb),
    .mdu_start_ex(mdu_start_ex), .mdu_use_id(mdu_use_id),
    .stall(stall3), .flush(flush3), .bubble_ex(bubble3),
    .fwdA_sel(fA3), .fwdB_sel(fB3), .mdu_busy(busy3)
  );

  hazard_unit_mc #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .MDU_LATENCY(4)) dut1 (
    .clk(clk), .rst(rst), .Branch(Branch), .Jump(Jump),
    .rsAddr_id(rsAddr_id), .rtAddr_id(rtAddr_id), .rsAddr_ex(rsAddr_ex), .rtAddr_ex(rtAddr_ex),
    .MEM_MemRead_ex(MEM_MemRead_ex), .RegWriteAddr_ex(RegWriteAddr_ex),
    .RegWrite_mem(RegWrite_mem), .RegWriteAddr_mem(RegWriteAddr_mem),
    .RegWrite_wb(RegWrite_wb), .RegWriteAddr_wb(RegWriteAddr_wb),
    .mdu_start_ex(mdu_start_ex), .mdu_use_id(mdu_use_id),
    .stall(stall1), .flush(flush1), .bubble_ex(bubble1),
    .fwdA_sel(fA1), .fwdB_sel(fB1), .mdu_busy(busy1)
  );

  // Packed expectation: {stall, flush, bubble_ex, fwdA[1:0], fwdB[1:0], mdu_busy}
  function automatic logic [7:0] ex(input logic s, input logic f, input logic [1:0] a,
                                    input logic [1:0] b, input logic bz);
    return {s, f, s, a, b, bz};
  endfunction

  always @(negedge clk) begin
    while (q_nm.size() > 0) begin
      string      nm;
      logic [7:0] e3, e1, a3, a1;
      nm = q_nm.pop_front();
      e3 = q_e3.pop_front();
      e1 = q_e1.pop_front();
      a3 = {stall3, flush3, bubble3, fA3, fB3, busy3};
      a1 = {stall1, flush1, bubble1, fA1, fB1, busy1};
      checks++;
      if (a3 !== e3) begin
        failures++;
        $display("FAIL %s [lsc3] got=%b want=%b (stall,flush,bubble,fwdA,fwdB,busy)", nm, a3, e3);
      end
      checks++;
      if (a1 !== e1) begin
        failures++;
        $display("FAIL %s [lsc1] got=%b want=%b (stall,flush,bubble,fwdA,fwdB,busy)", nm, a1, e1);
      end
    end
  end

  task automatic clr();
    Branch = 0; Jump = 0;
    rsAddr_id = 0; rtAddr_id = 0; rsAddr_ex = 0; rtAddr_ex = 0;
    MEM_MemRead_ex = 0; RegWriteAddr_ex = 0;
    RegWrite_mem = 0; RegWriteAddr_mem = 0; RegWrite_wb = 0; RegWriteAddr_wb = 0;
    mdu_start_ex = 0; mdu_use_id = 0;
  endtask

  task automatic load_use5();
    MEM_MemRead_ex = 1; RegWriteAddr_ex = 5; rsAddr_id = 5;
  endtask

  // Inputs are already applied; queue the expectation and advance one cycle.
  task automatic cyc(input string nm, input logic [7:0] e3, input logic [7:0] e1);
    q_nm.push_back(nm);
    q_e3.push_back(e3);
    q_e1.push_back(e1);
    @(posedge clk); #1;
  endtask

  localparam logic [7:0] Z = 8'h00;

  initial begin
    rst = 1; clr();
    @(posedge clk); #1;

    // Reset with every hazard source active: outputs must all be low.
    load_use5(); Branch = 1; RegWrite_mem = 1; RegWriteAddr_mem = 7; rsAddr_ex = 7;
    mdu_use_id = 1; mdu_start_ex = 1;
    cyc("rst_all_zero", Z, Z);
    rst = 0; clr();
    cyc("idle_after_rst", Z, Z);

    // Load-use on rs, removed after first cycle.
    load_use5();
    cyc("lu_c0", ex(1,0,0,0,0), ex(1,0,0,0,0));
    clr();
    cyc("lu_c1", ex(1,0,0,0,0), Z);
    cyc("lu_c2", ex(1,0,0,0,0), Z);
    cyc("lu_c3_release", Z, Z);

    // Taken branch held under a load-use stall (hit via rt).
    MEM_MemRead_ex = 1; RegWriteAddr_ex = 9; rtAddr_id = 9; Branch = 1;
    cyc("br_stall_c0", ex(1,0,0,0,0), ex(1,0,0,0,0));
    MEM_MemRead_ex = 0; RegWriteAddr_ex = 0; rtAddr_id = 0;
    cyc("br_stall_c1", ex(1,0,0,0,0), ex(0,1,0,0,0));
    cyc("br_stall_c2", ex(1,0,0,0,0), ex(0,1,0,0,0));
    cyc("br_flush_c3", ex(0,1,0,0,0), ex(0,1,0,0,0));
    clr(); Jump = 1;
    cyc("jump_flush", ex(0,1,0,0,0), ex(0,1,0,0,0));

    // No stall for $0 destination or non-matching sources.
    clr(); MEM_MemRead_ex = 1; RegWriteAddr_ex = 0; rsAddr_id = 0; rtAddr_id = 0;
    cyc("lu_dest_r0", Z, Z);
    RegWriteAddr_ex = 5; rsAddr_id = 6; rtAddr_id = 7;
    cyc("lu_no_match", Z, Z);

    // Forwarding.
    clr(); RegWrite_mem = 1; RegWriteAddr_mem = 7; RegWrite_wb = 1; RegWriteAddr_wb = 7;
    rsAddr_ex = 7; rtAddr_ex = 7;
    cyc("fwd_mem_prio", ex(0,0,2'b10,2'b10,0), ex(0,0,2'b10,2'b10,0));
    RegWrite_mem = 0;
    cyc("fwd_wb_only", ex(0,0,2'b01,2'b01,0), ex(0,0,2'b01,2'b01,0));
    RegWrite_mem = 1; RegWriteAddr_wb = 3; rtAddr_ex = 3;
    cyc("fwd_mixed", ex(0,0,2'b10,2'b01,0), ex(0,0,2'b10,2'b01,0));
    RegWriteAddr_mem = 0; RegWriteAddr_wb = 0; rsAddr_ex = 0; rtAddr_ex = 0;
    cyc("fwd_r0_never", Z, Z);
    RegWrite_mem = 0; RegWrite_wb = 0; RegWriteAddr_mem = 4; RegWriteAddr_wb = 4; rsAddr_ex = 4;
    cyc("fwd_no_regwrite", Z, Z);
    clr(); RegWrite_wb = 1; RegWriteAddr_wb = 2; rtAddr_ex = 2; load_use5();
    cyc("fwd_during_stall", ex(1,0,0,2'b01,0), ex(1,0,0,2'b01,0));
    clr();
    cyc("fwd_stall_tail1", ex(1,0,0,0,0), Z);
    cyc("fwd_stall_tail2", ex(1,0,0,0,0), Z);

    // MDU: start at c0, consumer in ID from c1.
    clr(); mdu_start_ex = 1;
    cyc("mdu_c0_notbusy", Z, Z);
    mdu_start_ex = 0; mdu_use_id = 1;
    for (int i = 1; i <= 4; i++)
      cyc($sformatf("mdu_busy_c%0d", i), ex(1,0,0,0,1), ex(1,0,0,0,1));
    cyc("mdu_release_c5", Z, Z);

    // Restart in the last busy cycle keeps busy continuous.
    clr(); mdu_start_ex = 1;
    cyc("mdr_c0", Z, Z);
    mdu_start_ex = 0;
    for (int i = 1; i <= 3; i++)
      cyc($sformatf("mdr_c%0d", i), ex(0,0,0,0,1), ex(0,0,0,0,1));
    mdu_start_ex = 1;
    cyc("mdr_c4_restart", ex(0,0,0,0,1), ex(0,0,0,0,1));
    mdu_start_ex = 0;
    for (int i = 5; i <= 8; i++)
      cyc($sformatf("mdr_c%0d", i), ex(0,0,0,0,1), ex(0,0,0,0,1));
    cyc("mdr_c9_idle", Z, Z);

    // Reset mid load stall and mid MDU.
    clr(); load_use5(); mdu_start_ex = 1;
    cyc("rmid_c0", ex(1,0,0,0,0), ex(1,0,0,0,0));
    clr();
    cyc("rmid_c1", ex(1,0,0,0,1), ex(0,0,0,0,1));
    rst = 1; mdu_use_id = 1; Branch = 1;
    cyc("rmid_c2_rst", Z, Z);
    rst = 0; Branch = 0;
    cyc("rmid_c3_after", Z, Z);
    clr();
    cyc("rmid_c4", Z, Z);

    @(negedge clk); #1;
    checks++;
    if (q_nm.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", q_nm.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
